fifo29: RTL and testbench

FIFO29 -- requirements
Module: fifo29

---
 rtl/fifo29.sv | 94 +++++++++
 tb/tb_fifo29.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fifo29.sv
// ---------------------------------------------------------------------------
// fifo29 -- synchronous first-in first-out buffer
//
// A circular array of DEPTH words with a write pointer, a read pointer and an
// occupancy count in the range 0..DEPTH. Read data is registered, so a word
// appears on dataOut one clock after the read is performed. A full FIFO still
// accepts a write when a read happens in the same cycle. An empty FIFO ignores
// reads, and there is no read-through of the word being written.
//
// Parameters
//   DATA_WIDTH  width of dataIn / dataOut (default 32)
//   DEPTH       number of storage entries, power of two, >= 2 (default 8)
//
// Ports
//   Clk      in   1           sole clock, rising edge
//   Rst      in   1           asynchronous reset, active low
//   EN       in   1           enable; 0 freezes all state
//   WR       in   1           write request
//   RD       in   1           read request
//   dataIn   in   DATA_WIDTH  write data
//   dataOut  out  DATA_WIDTH  registered read data
//   EMPTY    out  1           count == 0
//   FULL     out  1           count == DEPTH
// ---------------------------------------------------------------------------
module fifo29 #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  EN,
    input  logic                  WR,
    input  logic                  RD,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  EMPTY,
    output logic                  FULL
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_read;
    logic                  do_write;

    // Flags decode straight from the registered count.
    assign EMPTY = (count == '0);
    assign FULL  = (count == FULL_COUNT);

    // A read needs data present. A write needs room, or a same-cycle read
    // that frees the slot being overwritten.
    assign do_read  = EN & RD & ~EMPTY;
    assign do_write = EN & WR & (~FULL | do_read);

    // NOTE: storage has no reset; a cleared count and pointers make stale
    // contents unreachable, and leaving it out lets the array map to RAM.
    always_ff @(posedge Clk) begin
        if (do_write) begin
            mem[wr_ptr] <= dataIn;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            dataOut <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps
            // DEPTH-1 back to 0.
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_read) begin
                dataOut <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_W'(1);
            end
            case ({do_write, do_read})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo29.sv
// ---------------------------------------------------------------------------
// tb_fifo29 -- self-checking bench for fifo29
//
// A behavioural queue models the FIFO. Each driven cycle updates the model.
// Words the model says are read are pushed to a scoreboard queue, and are
// popped and compared against dataOut after the clock edge. Flags and the
// held dataOut value are compared every cycle.
// ---------------------------------------------------------------------------
module tb_fifo29;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          EN;
    logic          WR;
    logic          RD;
    logic [DW-1:0] dataIn;
    logic [DW-1:0] dataOut;
    logic          EMPTY;
    logic          FULL;

    fifo29 #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .EN     (EN),
        .WR     (WR),
        .RD     (RD),
        .dataIn (dataIn),
        .dataOut(dataOut),
        .EMPTY  (EMPTY),
        .FULL   (FULL)
    );

    always #5 Clk = ~Clk;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_dout = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, update the model, then check after the edge.
    task automatic step(input logic en, input logic wr, input logic rd, input logic [DW-1:0] din);
        bit do_rd;
        bit do_wr;
        @(negedge Clk);
        EN = en; WR = wr; RD = rd; dataIn = din;
        do_rd = en && rd && (model_q.size() != 0);
        do_wr = en && wr && ((model_q.size() < DEPTH) || do_rd);
        if (do_rd) begin
            exp_dout = model_q.pop_front();
            exp_q.push_back(exp_dout);
        end
        if (do_wr) model_q.push_back(din);
        @(posedge Clk);
        #1;
        if (exp_q.size() != 0) check("rd_data", 64'(dataOut), 64'(exp_q.pop_front()));
        else                   check("dout_hold", 64'(dataOut), 64'(exp_dout));
        check("empty", 64'(EMPTY), 64'(model_q.size() == 0));
        check("full", 64'(FULL), 64'(model_q.size() == DEPTH));
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        exp_dout = '0;
    endtask

    initial begin
        Rst = 1'b0; EN = 1'b0; WR = 1'b0; RD = 1'b0; dataIn = '0;

        // Held reset: flags and output at reset values.
        repeat (3) @(posedge Clk);
        #1;
        check("rst_empty", 64'(EMPTY), 64'd1);
        check("rst_full", 64'(FULL), 64'd0);
        check("rst_dout", 64'(dataOut), 64'd0);
        @(negedge Clk);
        Rst = 1'b1;
        model_reset();

        // Basic ordering, then reads past empty hold the last word.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, DW'(i));
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, '0);

        // Fill, dropped write while full, drain.
        for (int i = 10; i < 18; i++) step(1'b1, 1'b1, 1'b0, DW'(i));
        step(1'b1, 1'b1, 1'b0, DW'(99));
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, '0);

        // Pointer wrap with ordering preserved.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, DW'(32'h100 + i));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, '0);

        // EN=0 freezes everything.
        step(1'b1, 1'b1, 1'b0, DW'(32'h55));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, DW'(32'hdead0000 + i));
        step(1'b1, 1'b0, 1'b1, '0);

        // Simultaneous RD/WR while empty: write only, dataOut unchanged.
        step(1'b1, 1'b1, 1'b1, DW'(32'h77));
        step(1'b1, 1'b0, 1'b1, '0);

        // Simultaneous RD/WR while full: oldest out, new in, FULL stays.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, DW'(32'h200 + i));
        step(1'b1, 1'b1, 1'b1, DW'(32'h2aa));
        step(1'b1, 1'b1, 1'b1, DW'(32'h2bb));
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, '0);

        // Mixed random traffic.
        for (int i = 0; i < 60; i++)
            step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), DW'($urandom));
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, '0);

        // Mid-operation asynchronous reset, checked before the next edge.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, DW'(32'h300 + i));
        step(1'b1, 1'b0, 1'b1, '0);
        @(negedge Clk);
        EN = 1'b0; WR = 1'b0; RD = 1'b0;
        #1;
        Rst = 1'b0;
        #1;
        check("async_empty", 64'(EMPTY), 64'd1);
        check("async_full", 64'(FULL), 64'd0);
        check("async_dout", 64'(dataOut), 64'd0);
        model_reset();
        @(negedge Clk);
        Rst = 1'b1;
        step(1'b1, 1'b1, 1'b0, DW'(7));
        step(1'b1, 1'b0, 1'b1, '0);
        check("post_rst_dout", 64'(dataOut), 64'd7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
